// File: rtl/mlp_pkg.sv
// Shared MLP types and default dimensions, used by the sample arbiter and the accelerator.
package mlp_pkg;
   localparam int MLP_IN_WIDTH = 32;
   localparam int MLP_POS_DIM  = 63;
   localparam int MLP_DIR_DIM  = 27;
   localparam int MLP_OUT_DIM  = 4;

   typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DRAIN} arb_state_t;
endpackage

// File: rtl/mlp_tag_fifo.sv
// Tag FIFO holding the requester index of each in-flight sample.
// Results come back in order, so the head tag names the requester that owns the next result.
module mlp_tag_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push is accepted even when full.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/mlp_sample_arbiter.sv
// Round-robin arbiter that funnels per-requester samples into one MLP accelerator run
// and routes the in-order results back to their owners via a tag FIFO.
module mlp_sample_arbiter
   import mlp_pkg::*;
#(
   parameter int IN_WIDTH  = mlp_pkg::MLP_IN_WIDTH,
   parameter int POS_DIM   = mlp_pkg::MLP_POS_DIM,
   parameter int DIR_DIM   = mlp_pkg::MLP_DIR_DIM,
   parameter int OUT_DIM   = mlp_pkg::MLP_OUT_DIM,
   parameter int NUM_REQ   = 4,
   parameter int BATCH     = 65536,
   parameter int TAG_DEPTH = 4
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        enable,
   output logic                                        busy,
   input  logic [NUM_REQ-1:0]                          req_valid,
   output logic [NUM_REQ-1:0]                          req_ready,
   input  logic [NUM_REQ-1:0][POS_DIM-1:0][IN_WIDTH-1:0] req_pos,
   input  logic [NUM_REQ-1:0][DIR_DIM-1:0][IN_WIDTH-1:0] req_dir,
   output logic [NUM_REQ-1:0]                          rsp_valid,
   input  logic [NUM_REQ-1:0]                          rsp_ready,
   output logic [OUT_DIM-1:0][IN_WIDTH-1:0]            rsp_data,
   output logic                                        mlp_start,
   input  logic                                        mlp_ready,
   input  logic                                        mlp_done,
   output logic                                        mlp_in_valid,
   input  logic                                        mlp_in_ready,
   output logic [POS_DIM-1:0][IN_WIDTH-1:0]            mlp_pos,
   output logic [DIR_DIM-1:0][IN_WIDTH-1:0]            mlp_dir,
   input  logic                                        mlp_out_valid,
   output logic                                        mlp_out_ready,
   input  logic [OUT_DIM-1:0][IN_WIDTH-1:0]            mlp_out_data
);
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(BATCH + 1);

   arb_state_t    state, state_nxt;
   logic [CW-1:0] issued, returned;
   logic [GW-1:0] last_grant, gnt, head;
   logic          permitted, in_fire, out_fire, fifo_full, fifo_empty;
   logic          err_stray_rsp;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable && mlp_ready && |req_valid) state_nxt = LAUNCH;
         LAUNCH:  state_nxt = RUN;
         RUN:     if (issued == CW'(BATCH) && returned == CW'(BATCH)) state_nxt = DRAIN;
         DRAIN:   if (mlp_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      mlp_start = (state == LAUNCH);
      permitted = (state == RUN) && (issued < CW'(BATCH)) && !fifo_full;
   end

   // Scan downward so the requester closest after last_grant is written last and wins.
   always_comb begin
      gnt = GW'((int'(last_grant) + 1) % NUM_REQ);
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[(int'(last_grant) + 1 + i) % NUM_REQ])
            gnt = GW'((int'(last_grant) + 1 + i) % NUM_REQ);
      end
   end

   always_comb begin
      mlp_in_valid   = permitted && req_valid[gnt];
      req_ready      = '0;
      req_ready[gnt] = permitted && mlp_in_ready;
      mlp_pos        = req_pos[gnt];
      mlp_dir        = req_dir[gnt];
      in_fire        = mlp_in_valid && mlp_in_ready;
      rsp_valid       = '0;
      rsp_valid[head] = mlp_out_valid && !fifo_empty;
      mlp_out_ready   = rsp_ready[head] && !fifo_empty;
      out_fire        = mlp_out_valid && mlp_out_ready;
      rsp_data        = mlp_out_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         issued        <= '0;
         returned      <= '0;
         last_grant    <= GW'(NUM_REQ - 1);
         err_stray_rsp <= 1'b0;
      end else begin
         if (state == IDLE && state_nxt == LAUNCH) begin
            issued   <= '0;
            returned <= '0;
         end else begin
            if (in_fire)  issued   <= issued + 1'b1;
            if (out_fire) returned <= returned + 1'b1;
         end
         if (in_fire) last_grant <= gnt;
         // A result with no outstanding tag has no owner; it is dropped and flagged.
         if (mlp_out_valid && fifo_empty) err_stray_rsp <= 1'b1;
      end
   end

   mlp_tag_fifo #(
      .WIDTH (GW),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_fire),
      .push_data (gnt),
      .pop       (out_fire),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );
endmodule

// File: tb/tb_mlp_sample_arbiter.sv
// Directed bench for mlp_sample_arbiter with BATCH=8, NUM_REQ=4, TAG_DEPTH=4.
module tb_mlp_sample_arbiter;
   localparam int NR = 4, BT = 8, TD = 4, IW = 32, PD = 63, DD = 27, OD = 4;

   logic                        clk = 1'b0;
   logic                        rst, enable, busy;
   logic [NR-1:0]               req_valid, req_ready, rsp_valid, rsp_ready;
   logic [NR-1:0][PD-1:0][IW-1:0] req_pos;
   logic [NR-1:0][DD-1:0][IW-1:0] req_dir;
   logic [OD-1:0][IW-1:0]       rsp_data, mlp_out_data;
   logic                        mlp_start, mlp_ready, mlp_done;
   logic                        mlp_in_valid, mlp_in_ready, mlp_out_valid, mlp_out_ready;
   logic [PD-1:0][IW-1:0]       mlp_pos;
   logic [DD-1:0][IW-1:0]       mlp_dir;

   always #5 clk = ~clk;

   mlp_sample_arbiter #(
      .IN_WIDTH(IW), .POS_DIM(PD), .DIR_DIM(DD), .OUT_DIM(OD),
      .NUM_REQ(NR), .BATCH(BT), .TAG_DEPTH(TD)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .busy(busy),
      .req_valid(req_valid), .req_ready(req_ready), .req_pos(req_pos), .req_dir(req_dir),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .mlp_start(mlp_start), .mlp_ready(mlp_ready), .mlp_done(mlp_done),
      .mlp_in_valid(mlp_in_valid), .mlp_in_ready(mlp_in_ready),
      .mlp_pos(mlp_pos), .mlp_dir(mlp_dir),
      .mlp_out_valid(mlp_out_valid), .mlp_out_ready(mlp_out_ready), .mlp_out_data(mlp_out_data)
   );

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   int hold_until, stall_from, stall_to, drop_en_after;
   int grants[$];
   int rsp_cnt[NR];
   int starts, ret_total;
   logic busy_at_done;
   logic [NR-1:0] log_rr[128];
   logic [NR-1:0] log_rv[128];
   logic          log_or[128];

   // Accelerator model: returns results in order once hold_until has passed.
   task automatic run_batch(input logic [NR-1:0] valids, input int budget);
      int cyc, pend, issues, done_at, g;
      bit fin;
      cyc = 0; pend = 0; issues = 0; done_at = -1; fin = 0;
      grants.delete();
      starts = 0; ret_total = 0; busy_at_done = 1'b0;
      for (int i = 0; i < NR; i++) rsp_cnt[i] = 0;
      for (int c = 0; c < 128; c++) begin
         log_rr[c] = '0; log_rv[c] = '0; log_or[c] = 1'b0;
      end
      req_valid = valids;
      enable    = 1'b1;
      while (!fin && cyc < budget) begin
         mlp_out_valid   = (pend > 0) && (cyc >= hold_until);
         mlp_out_data    = '0;
         mlp_out_data[0] = 32'hD000_0000 + 32'(ret_total);
         rsp_ready       = (cyc >= stall_from && cyc < stall_to) ? '0 : '1;
         mlp_done        = (cyc == done_at);
         if (issues >= drop_en_after || mlp_done) enable = 1'b0;
         #1;
         if (cyc < 128) begin
            log_rr[cyc] = req_ready;
            log_rv[cyc] = rsp_valid;
            log_or[cyc] = mlp_out_ready;
         end
         if (mlp_start) starts++;
         if (mlp_done) busy_at_done = busy;
         if (mlp_in_valid && mlp_in_ready) begin
            g = 0;
            for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
            chk("req_ready_onehot", 64'($onehot(req_ready)), 64'd1);
            chk("mlp_pos_mux", 64'(mlp_pos[5]), 64'(g * 32'h1000 + 5));
            grants.push_back(g);
            pend++;
            issues++;
         end
         if (mlp_out_valid && mlp_out_ready) begin
            for (int i = 0; i < NR; i++) if (rsp_valid[i]) rsp_cnt[i]++;
            chk("rsp_data", 64'(rsp_data[0]), 64'(32'hD000_0000 + 32'(ret_total)));
            pend--;
            ret_total++;
            if (ret_total == BT) done_at = cyc + 2;
         end
         if (mlp_done) fin = 1;
         tick();
         cyc++;
      end
      chk("run_completes", 64'(fin), 64'd1);
      chk("busy_at_done", 64'(busy_at_done), 64'd1);
      chk("busy_after_done", 64'(busy), 64'd0);
      mlp_done = 1'b0;
      mlp_out_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("no_relaunch", 64'(mlp_start), 64'd0);
         tick();
      end
      chk("idle_stays", 64'(busy), 64'd0);
   endtask

   task automatic chk_grants(input string tag, input int exp[8]);
      chk({tag, "_count"}, 64'(grants.size()), 64'd8);
      for (int k = 0; k < 8; k++)
         chk($sformatf("%s_grant%0d", tag, k),
             64'((k < grants.size()) ? grants[k] : -1), 64'(exp[k]));
   endtask

   int rr_exp[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
   int two_exp[8] = '{2, 2, 2, 2, 2, 2, 2, 2};
   int n_out;

   initial begin
      for (int i = 0; i < NR; i++) begin
         for (int k = 0; k < PD; k++) req_pos[i][k] = 32'(i * 32'h1000 + k);
         for (int k = 0; k < DD; k++) req_dir[i][k] = 32'(i * 32'h2000 + k);
      end
      hold_until = 0; stall_from = 0; stall_to = 0; drop_en_after = 1000;
      rst = 1'b1; enable = 1'b1; req_valid = '1; rsp_ready = '1;
      mlp_ready = 1'b1; mlp_done = 1'b0; mlp_in_ready = 1'b1;
      mlp_out_valid = 1'b1; mlp_out_data = '0;
      tick();
      tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_start", 64'(mlp_start), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_in_valid", 64'(mlp_in_valid), 64'd0);
      chk("rst_out_ready", 64'(mlp_out_ready), 64'd0);
      chk("rst_err", 64'(dut.err_stray_rsp), 64'd0);
      mlp_out_valid = 1'b0;
      enable = 1'b0;

      // All requesters valid, accelerator always ready.
      do_reset();
      run_batch(4'hF, 100);
      chk_grants("rr", rr_exp);
      for (int i = 0; i < NR; i++) chk($sformatf("rr_rsp%0d", i), 64'(rsp_cnt[i]), 64'd2);
      chk("rr_starts", 64'(starts), 64'd1);

      // Only requester 2.
      do_reset();
      run_batch(4'b0100, 100);
      chk_grants("solo", two_exp);
      chk("solo_rsp2", 64'(rsp_cnt[2]), 64'd8);
      chk("solo_starts", 64'(starts), 64'd1);

      // Results held for 10 cycles: tag FIFO fills after 4 issues.
      do_reset();
      hold_until = 10;
      run_batch(4'hF, 100);
      hold_until = 0;
      chk("hold_rr5", 64'(log_rr[5]), 64'h8);
      chk("hold_rr6", 64'(log_rr[6]), 64'h0);
      chk("hold_rr9", 64'(log_rr[9]), 64'h0);
      chk("hold_rr10", 64'(log_rr[10]), 64'h0);
      chk("hold_or10", 64'(log_or[10]), 64'd1);
      chk("hold_rr11", 64'(log_rr[11]), 64'h1);
      chk_grants("hold", rr_exp);

      // Head requester stalls rsp_ready for 5 cycles.
      do_reset();
      stall_from = 3; stall_to = 8;
      run_batch(4'hF, 100);
      stall_from = 0; stall_to = 0;
      chk("stall_rv3", 64'(log_rv[3]), 64'h1);
      chk("stall_or3", 64'(log_or[3]), 64'd0);
      chk("stall_rv7", 64'(log_rv[7]), 64'h1);
      chk("stall_or7", 64'(log_or[7]), 64'd0);
      chk("stall_rr7", 64'(log_rr[7]), 64'h0);
      chk("stall_or8", 64'(log_or[8]), 64'd1);
      for (int i = 0; i < NR; i++) chk($sformatf("stall_rsp%0d", i), 64'(rsp_cnt[i]), 64'd2);

      // enable dropped after the third issue: run still finishes.
      do_reset();
      drop_en_after = 3;
      run_batch(4'hF, 100);
      drop_en_after = 1000;
      chk("noen_returned", 64'(ret_total), 64'd8);
      chk("noen_starts", 64'(starts), 64'd1);
      chk_grants("noen", rr_exp);
      chk("noen_err", 64'(dut.err_stray_rsp), 64'd0);

      // Reset with 3 samples outstanding, then a stray result.
      do_reset();
      enable = 1'b1; req_valid = '1; rsp_ready = '1; mlp_out_valid = 1'b0;
      n_out = 0;
      for (int c = 0; c < 20 && n_out < 3; c++) begin
         #1;
         if (mlp_in_valid && mlp_in_ready) n_out++;
         tick();
      end
      chk("mid_outstanding", 64'(n_out), 64'd3);
      rst = 1'b1; enable = 1'b0;
      tick();
      rst = 1'b0;
      chk("mid_busy", 64'(busy), 64'd0);
      chk("mid_req_ready", 64'(req_ready), 64'd0);
      mlp_out_valid = 1'b1;
      #1;
      chk("stray_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("stray_out_ready", 64'(mlp_out_ready), 64'd0);
      tick();
      chk("stray_err", 64'(dut.err_stray_rsp), 64'd1);
      mlp_out_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
